ks_sum_stage: RTL

Registered sum/output stage of the 16-bit Kogge-Stone adder. It sits directly downstream of the prefix tree's carry cells. It consumes per-bit propagate P and final carries C (C[i] = carry out of bit i, i.e. group generate G[i:0]), forms sum, carry-out, signed overflow and zero flags, and presents them on a valid/ready interface. A 2-entry skid buffer gives full throughput with a registered in_ready.

---
 rtl/ks_pkg.sv | 17 +
 rtl/ks_sum_xor.sv | 27 ++
 rtl/ks_sum_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared constants for the Kogge-Stone sum/output stage: default width,
// buffer state encodings and the registered result-word width.
package ks_pkg;

  localparam int unsigned KS_WIDTH = 16;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int unsigned KS_RES_W = KS_WIDTH + 3;

  function automatic int unsigned res_width(input int unsigned w);
    return w + 3;
  endfunction

endpackage

// File: rtl/ks_sum_xor.sv
// Combinational sum/flag formation from per-bit propagate and the
// prefix tree's final carries (c_in[i] = carry out of bit i).
module ks_sum_xor
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  always_comb begin
    sum         = '0;
    sum[0]      = p_in[0] ^ cin;
    sum[WIDTH-1:1] = p_in[WIDTH-1:1] ^ c_in[WIDTH-2:0];
  end

  assign cout = c_in[WIDTH-1];
  assign ovf  = c_in[WIDTH-1] ^ c_in[WIDTH-2];
  assign zero = ~|sum;

endmodule

// File: rtl/ks_sum_stage.sv
// Registered sum/output stage of the Kogge-Stone adder: result formation
// followed by a 2-entry skid buffer on a valid/ready interface.
module ks_sum_stage
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned RW = res_width(WIDTH);

  logic [WIDTH-1:0] x_sum;
  logic             x_cout;
  logic             x_ovf;
  logic             x_zero;
  logic [RW-1:0]    res_word;

  logic [RW-1:0]    m_q;
  logic [RW-1:0]    s_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             in_ready_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             ld_m;
  logic             ld_s;
  logic             mv_s;

  ks_sum_xor #(.WIDTH(WIDTH)) u_xor (
    .p_in (p_in),
    .c_in (c_in),
    .cin  (cin),
    .sum  (x_sum),
    .cout (x_cout),
    .ovf  (x_ovf),
    .zero (x_zero)
  );

  assign res_word  = {x_zero, x_ovf, x_cout, x_sum};
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;

  always_comb begin
    state_d = state_q;
    ld_m    = 1'b0;
    ld_s    = 1'b0;
    mv_s    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          ld_m    = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          ld_m = 1'b1;
        end else if (in_xfer) begin
          ld_s    = 1'b1;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          mv_s    = 1'b1;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // in_ready is a flop loaded from next-state so it never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (ld_m) begin
        m_q <= res_word;
      end else if (mv_s) begin
        m_q <= s_q;
      end
      if (ld_s) begin
        s_q <= res_word;
      end
    end
  end

  assign sum  = m_q[WIDTH-1:0];
  assign cout = m_q[WIDTH];
  assign ovf  = m_q[WIDTH+1];
  assign zero = m_q[WIDTH+2];

endmodule
